// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on APB, valid/ready response out.
// Optional ACCESS-phase timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  Pclk,
  input  logic                  Prst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] Paddr,
  output logic                  Pselx,
  output logic                  Penable,
  output logic                  Pwrite,
  output logic [DATA_WIDTH-1:0] Pwdata,
  input  logic                  Pready,
  input  logic [DATA_WIDTH-1:0] Prdata,
  input  logic                  Pslverr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]            r_state;
  logic                  r_cmd_ready;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_slverr;
  logic                  r_rsp_timeout;
  logic                  w_abort;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;

  // Counts ACCESS cycles already spent waiting; the abort fires in the
  // TIMEOUT_CYCLES-th waiting cycle unless Pready rescues it.
  always_ff @(posedge Pclk) begin
    if (Prst) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_state == ST_SETUP) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_state == ST_ACCESS && !Pready && r_tmo_cnt != 8'hFF) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  assign w_abort = (r_state == ST_ACCESS) && !Pready && (r_tmo_cnt == TMO_LAST);
`else
  logic w_unused_tmo;

  assign w_unused_tmo = ^TMO_LAST;
  assign w_abort      = 1'b0;
`endif

  always_ff @(posedge Pclk) begin
    if (Prst) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_paddr     <= cmd_addr;
            r_pwrite    <= cmd_write;
            r_pwdata    <= cmd_wdata;
            r_psel      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_SETUP;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (Pready) begin
            r_rsp_rdata   <= r_pwrite ? '0 : Prdata;
            r_rsp_slverr  <= Pslverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= ST_RESP;
          end else if (w_abort) begin
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Ready is raised together with the handshake so a new command can land next edge.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;
  assign Paddr       = r_paddr;
  assign Pselx       = r_psel;
  assign Penable     = r_penable;
  assign Pwrite      = r_pwrite;
  assign Pwdata      = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: vector table, reset/timeout sequences and randomized transfers
// checked against a transfer-level reference model.
module tb_apb_master;

  localparam int TMO = 4;

  logic        Pclk = 1'b0;
  logic        Prst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] Paddr;
  logic        Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Pwdata;
  logic        Pready;
  logic [31:0] Prdata;
  logic        Pslverr;

  int n_chk  = 0;
  int n_fail = 0;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .Pclk(Pclk), .Prst(Prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .Paddr(Paddr), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Pwdata(Pwdata),
    .Pready(Pready), .Prdata(Prdata), .Pslverr(Pslverr)
  );

  always #5 Pclk = ~Pclk;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        perr;
    int          waits;
    int          stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] prdata, input logic perr, input int waits,
                              input int stall, input logic [31:0] er, input logic ee,
                              input logic et, input int el);
    vec_t v;
    v.w = w; v.addr = addr; v.wdata = wdata; v.prdata = prdata; v.perr = perr;
    v.waits = waits; v.stall = stall; v.exp_rdata = er; v.exp_err = ee;
    v.exp_tmo = et; v.exp_lat = el;
    return v;
  endfunction

  // Transfer-level model: latency counts edges from the accept edge to the edge
  // at which the consumer first sees rsp_valid.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_tmo   = 1'b0;
    r.exp_err   = v.perr;
    r.exp_rdata = v.w ? 32'h0 : v.prdata;
    r.exp_lat   = 3 + v.waits;
`ifdef APB_MASTER_TIMEOUT_EN
    if (v.waits >= TMO) begin
      r.exp_tmo   = 1'b1;
      r.exp_err   = 1'b1;
      r.exp_rdata = 32'h0;
      r.exp_lat   = 2 + TMO;
    end
`endif
    return r;
  endfunction

  // Entered and left at a falling edge; plays the APB slave and response consumer.
  task automatic run_vec(input vec_t v, input string tag);
    int  lat;
    int  nacc;
    bit  seen;
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = v.w; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(posedge Pclk); @(negedge Pclk);
    cmd_valid = 1'b0; cmd_write = ~v.w; cmd_addr = $urandom; cmd_wdata = $urandom;
    chk({tag, ".setup_ctl"}, {29'd0, Pselx, Penable, cmd_ready}, 32'b100);
    chk({tag, ".paddr"}, Paddr, v.addr);
    chk({tag, ".pwdata"}, Pwdata, v.wdata);
    chk({tag, ".pwrite"}, 32'(Pwrite), 32'(v.w));
    Pready = 1'b1; Pslverr = 1'b1;
    lat = 0; nacc = 0; seen = 0;
    while (!seen && lat < 200) begin
      @(posedge Pclk); lat++; @(negedge Pclk);
      if (rsp_valid) begin
        seen = 1;
      end else begin
        chk({tag, ".access_ctl"}, {30'd0, Pselx, Penable}, 32'b11);
        chk({tag, ".stable"}, 32'(Paddr == v.addr && Pwdata == v.wdata && Pwrite == v.w), 32'd1);
        Pready = (nacc >= v.waits); Prdata = v.prdata; Pslverr = v.perr;
        nacc++;
      end
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s.rsp_wait: no rsp_valid within %0d cycles", tag, lat);
      Pready = 1'b0;
      return;
    end
    chk({tag, ".latency"}, 32'(lat + 1), 32'(v.exp_lat));
    chk({tag, ".rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, ".slverr"}, 32'(rsp_slverr), 32'(v.exp_err));
    chk({tag, ".timeout"}, 32'(rsp_timeout), 32'(v.exp_tmo));
    chk({tag, ".resp_ctl"}, {29'd0, Pselx, Penable, cmd_ready}, 32'b000);
    Pready = $urandom; Pslverr = $urandom; Prdata = $urandom;
    for (int i = 0; i < v.stall; i++) begin
      rsp_ready = 1'b0;
      @(posedge Pclk); @(negedge Pclk);
      chk({tag, ".stall_hold"},
          32'(rsp_valid && !cmd_ready && !Pselx && rsp_slverr == v.exp_err &&
              rsp_rdata == v.exp_rdata && rsp_timeout == v.exp_tmo), 32'd1);
      Pready = $urandom; Pslverr = $urandom;
    end
    rsp_ready = 1'b1;
    @(posedge Pclk); @(negedge Pclk);
    rsp_ready = 1'b0; Pready = 1'b0; Pslverr = 1'b0;
    chk({tag, ".after_hs"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
  endtask

  task automatic reset_in_access(input int hold);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h77; cmd_wdata = 32'h0;
    @(posedge Pclk); @(negedge Pclk);
    cmd_valid = 1'b0; Pready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge Pclk); @(negedge Pclk);
      chk("rst_acc.wait", {29'd0, Pselx, Penable, rsp_valid}, 32'b110);
      Pready = 1'b0;
    end
    Prst = 1'b1;
    @(posedge Pclk); @(negedge Pclk);
    chk("rst_acc.cleared", {28'd0, Pselx, Penable, rsp_valid, cmd_ready}, 32'b0000);
    Prst = 1'b0;
    @(posedge Pclk); @(negedge Pclk);
    chk("rst_acc.release", {29'd0, cmd_ready, Pselx, rsp_valid}, 32'b100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t rv;
    Prst = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5; cmd_wdata = 32'h1;
    rsp_ready = 1'b0; Pready = 1'b1; Prdata = 32'hFFFF_FFFF; Pslverr = 1'b1;

    for (int i = 0; i < 2; i++) begin
      @(posedge Pclk); @(negedge Pclk);
      chk("reset.outputs", 32'(|{cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
                                  Paddr, Pselx, Penable, Pwrite, Pwdata}), 32'd0);
    end
    Prst = 1'b0; cmd_valid = 1'b0; Pready = 1'b0; Pslverr = 1'b0;
    @(posedge Pclk); @(negedge Pclk);
    chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset.no_apb", {30'd0, Pselx, Penable}, 32'd0);

    //       w     addr          wdata         prdata        perr  wt st  rdata         err   tmo   lat
    tbl.push_back(mk(1'b1, 32'h5,        32'hDEADBEEF, 32'h0,        1'b0, 0, 0, 32'h0,        1'b0, 1'b0, 3));
    tbl.push_back(mk(1'b0, 32'h5,        32'h0,        32'hDEADBEEF, 1'b0, 3, 0, 32'hDEADBEEF, 1'b0, 1'b0, 6));
    tbl.push_back(mk(1'b0, 32'h40,       32'h0,        32'h12345678, 1'b1, 0, 4, 32'h12345678, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b1, 32'hFFFFFFFF, 32'h0,        32'hA5A5A5A5, 1'b1, 1, 0, 32'h0,        1'b1, 1'b0, 4));
    tbl.push_back(mk(1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 0, 1, 32'hFFFFFFFF, 1'b0, 1'b0, 3));
`ifdef APB_MASTER_TIMEOUT_EN
    tbl.push_back(mk(1'b0, 32'h10,       32'h0,        32'h11111111, 1'b0, 100, 0, 32'h0,      1'b1, 1'b1, 6));
    tbl.push_back(mk(1'b0, 32'h14,       32'h0,        32'h0BADF00D, 1'b0, 3, 0, 32'h0BADF00D, 1'b0, 1'b0, 6));
    tbl.push_back(mk(1'b1, 32'h18,       32'h55AA55AA, 32'h22222222, 1'b0, 4, 2, 32'h0,        1'b1, 1'b1, 6));
`endif
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

`ifdef APB_MASTER_TIMEOUT_EN
    reset_in_access(3);
`else
    reset_in_access(50);
`endif
    run_vec(tbl[0], "post_reset");

    for (int i = 0; i < 40; i++) begin
      rv.w      = $urandom_range(0, 1);
      rv.addr   = $urandom;
      rv.wdata  = $urandom;
      rv.prdata = $urandom;
      rv.perr   = ($urandom_range(0, 3) == 0);
      rv.waits  = $urandom_range(0, 6);
      rv.stall  = $urandom_range(0, 3);
      run_vec(model(rv), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester. Accepts a read or write command on a valid/ready interface, runs the APB SETUP and ACCESS phases against one slave (e.g. `APB_memory`), and returns read data and error status on a valid/ready response interface. It is the initiator end of the APB link that the memory slave responds to, and it replaces hand-driven APB stimulus in system benches.

## Interface
- ADDR_WIDTH, 32, width of `cmd_addr` and `Paddr`
- DATA_WIDTH, 32, width of all data buses
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with `Pready` low before abort; used only with the timeout feature; legal range 1..255

Ports:
- Pclk  in  1  clock, all logic on rising edge
- Prst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_slverr  out  1  slave error or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- Paddr  out  ADDR_WIDTH  APB address
- Pselx  out  1  APB select
- Penable  out  1  APB enable
- Pwrite  out  1  APB direction
- Pwdata  out  DATA_WIDTH  APB write data
- Pready  in  1  slave ready
- Prdata  in  DATA_WIDTH  slave read data
- Pslverr  in  1  slave error

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`&`cmd_ready`, capture addr/write/wdata into `Paddr`/`Pwrite`/`Pwdata`; next state SETUP.
- SETUP: `Pselx`=1, `Penable`=0; unconditionally to ACCESS.
- ACCESS: `Pselx`=1, `Penable`=1. `Pready` sampled only here. On `Pready`=1: capture `Prdata` (reads; 0 for writes) into `rsp_rdata`, `Pslverr` into `rsp_slverr`, `rsp_timeout`=0; next RESP. `Pready`/`Pslverr` in IDLE or SETUP are ignored.
- RESP: `rsp_valid`=1, `Pselx`=`Penable`=0; response fields held stable until `rsp_valid`&`rsp_ready`, then IDLE.
- `Paddr`, `Pwrite`, `Pwdata` stable from SETUP through completion; hold last values in IDLE/RESP.
- One transfer outstanding; `cmd_ready`=0 in SETUP, ACCESS, RESP.
- Reset mid-operation: `Prst` has priority in any state; transfer abandoned, no response issued.

## Timing
- Reset values (all outputs, registered): `cmd_ready`=0 during the reset cycle, 1 in the first cycle after; all other outputs 0; state IDLE.
- Accept at edge N -> SETUP visible N+1, ACCESS N+2; zero-wait `Pready` -> `rsp_valid` visible N+3.
- Each wait cycle (`Pready`=0 in ACCESS) adds one cycle.
- With `rsp_ready` held 1: `rsp_valid` is a 1-cycle pulse; `cmd_ready` returns the following cycle; minimum command-to-command spacing 4 cycles.
- `rsp_ready` low stalls in RESP indefinitely; APB bus idle meanwhile.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined: 8-bit counter cleared on entry to ACCESS, increments each ACCESS cycle with `Pready`=0. When count reaches TIMEOUT_CYCLES and `Pready` is still 0, transfer aborts: next state RESP with `rsp_slverr`=1, `rsp_timeout`=1, `rsp_rdata`=0. `Pready`=1 in the same cycle the limit is hit wins (normal completion).
- Not defined: no counter; ACCESS waits for `Pready` indefinitely; `rsp_timeout` tied 0.

## Test plan
- Reset: assert `Prst` 2 cycles with `cmd_valid`=1 -> all outputs 0, no APB activity; `cmd_ready`=1 in first cycle after release.
- Write zero-wait: write addr 0x5 data 0xDEADBEEF, `Pready`=1 -> SETUP then ACCESS with `Paddr`=0x5, `Pwdata`=0xDEADBEEF, `Pwrite`=1; `rsp_valid` 3 cycles after accept, `rsp_rdata`=0, `rsp_slverr`=0.
- Read with waits: read addr 0x5, `Pready` low 3 ACCESS cycles then high with `Prdata`=0xDEADBEEF -> `rsp_rdata`=0xDEADBEEF, `rsp_valid` 6 cycles after accept, address/control stable throughout.
- Slave error and backpressure: read with `Pslverr`=1 at completion, `rsp_ready` low 4 cycles -> `rsp_slverr`=1 held 5 cycles, `cmd_ready`=0 until handshake.
- Timeout (macro defined, TIMEOUT_CYCLES=4): `Pready` held 0 -> abort after 4 ACCESS cycles, `rsp_slverr`=1, `rsp_timeout`=1, `Pselx`=0; macro undefined -> ACCESS persists 50 cycles, no response.
- Reset in ACCESS: assert `Prst` during wait state -> `Pselx`/`Penable` 0 next cycle, no `rsp_valid`, next command completes normally.
